framebuf_writer: RTL

- Drains the camera output FIFO and turns its pixel stream into addressed write cycles on port A of the 640x480 frame-buffer BRAM.
- Sits between cam_top (FIFO read side) and the frame-buffer storage, in the 125 MHz i_sysclk domain.
- Locks the write address to frame boundaries using the start-of-frame pulse.
- Honours the pipeline-flush request issued by system control.

---
 rtl/framebuf_pkg.sv | 21 ++
 rtl/framebuf_addr_ctr.sv | 88 ++++++++
 rtl/framebuf_writer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/framebuf_pkg.sv
// Shared types and constants for the frame-buffer writer: FSM encoding,
// default widths and the default frame size.
package framebuf_pkg;

   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_ADDR_WIDTH = 19;
   localparam int DEF_H_RES      = 640;
   localparam int DEF_V_RES      = 480;
   localparam int FRAME_PIXELS   = DEF_H_RES * DEF_V_RES;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } fb_state_e;

   function automatic int frame_pixels(input int h_res, input int v_res);
      return h_res * v_res;
   endfunction

endpackage

// File: rtl/framebuf_addr_ctr.sv
// Pixel address counter for one frame: full detect, end-of-frame pulse and
// the sticky overrun / short-frame error flags.
module framebuf_addr_ctr
   import framebuf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int FRAME_PIX  = FRAME_PIXELS
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  wr_i,
   input  logic                  sof_i,
   input  logic                  flush_i,
   output logic [ADDR_WIDTH-1:0] cnt_o,
   output logic                  accept_o,
   output logic                  frame_done_o,
   output logic                  err_overrun_o,
   output logic                  err_short_o
);

   localparam logic [ADDR_WIDTH-1:0] FULL_C = ADDR_WIDTH'(FRAME_PIX);
   localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(FRAME_PIX - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_C = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ONE_C  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  ovr_q, ovr_d;
   logic                  short_q, short_d;
   logic                  full_s;

   assign full_s = (cnt_q == FULL_C);

   // Next counter/flag values; sof overrides the increment but the write
   // in the same cycle still consumes the pre-sof address.
   always_comb begin
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      short_d = short_q;
      if (flush_i) begin
         cnt_d   = ZERO_C;
         ovr_d   = 1'b0;
         short_d = 1'b0;
      end else begin
         if (wr_i && full_s) begin
            ovr_d = 1'b1;
         end else if (wr_i) begin
            done_d = (cnt_q == LAST_C);
            cnt_d  = cnt_q + ONE_C;
         end else begin
            done_d = 1'b0;
         end
         if (sof_i) begin
            cnt_d = ZERO_C;
            if ((cnt_q != ZERO_C) && !full_s) begin
               short_d = 1'b1;
            end else begin
               short_d = short_q;
            end
         end else begin
            short_d = short_q;
         end
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q   <= ZERO_C;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         short_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         short_q <= short_d;
      end
   end

   assign cnt_o         = cnt_q;
   assign accept_o      = !full_s;
   assign frame_done_o  = done_q;
   assign err_overrun_o = ovr_q;
   assign err_short_o   = short_q;

endmodule

// File: rtl/framebuf_writer.sv
// Drains the camera FIFO in fixed bursts and writes pixels into the frame buffer.
// Optional statistics outputs are enabled with FRAMEBUF_WRITER_STATS_EN.
module framebuf_writer
   import framebuf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int H_RES      = DEF_H_RES,
   parameter int V_RES      = DEF_V_RES,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int BURST_LEN  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_sof,
   input  logic                  i_flush,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_almostempty,
   output logic                  o_wr,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_frame_done,
   output logic                  o_err_overrun,
   output logic                  o_err_short
`ifdef FRAMEBUF_WRITER_STATS_EN
  ,output logic [15:0]           o_frame_count,
   output logic [ADDR_WIDTH-1:0] o_last_pix_count
`endif
);

   localparam int FRAME_PIX = frame_pixels(H_RES, V_RES);
   localparam int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [BW-1:0] BEAT_ZERO = BW'(0);

   fb_state_e             state_q, state_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  rd_en_q, rd_q, wr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic                  cap_s, accept_s, sof_act_s, frame_done_s;
   logic [ADDR_WIDTH-1:0] cnt_s;

   assign cap_s     = rd_q && !i_flush;
   assign sof_act_s = i_sof && !i_flush && (state_q != S_IDLE);

   // Burst sequencer: a WAIT cycle always separates consecutive bursts.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      if (i_flush) begin
         state_d = S_IDLE;
         beat_d  = BEAT_ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_sof) state_d = S_WAIT;
               else       state_d = S_IDLE;
            end
            S_WAIT: begin
               if (!i_almostempty) begin
                  state_d = S_BURST;
                  beat_d  = BEAT_ZERO;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_BURST: begin
               if (beat_q == BEAT_LAST) state_d = S_WAIT;
               else                     beat_d  = beat_q + BEAT_ONE;
            end
            default: begin
               state_d = S_IDLE;
               beat_d  = BEAT_ZERO;
            end
         endcase
      end
   end

   // FSM state, read strobe and the two-stage write pipeline.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         beat_q  <= BEAT_ZERO;
         rd_en_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= {DATA_WIDTH{1'b0}};
         waddr_q <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         rd_en_q <= (state_d == S_BURST);
         rd_q    <= i_flush ? 1'b0 : rd_en_q;
         wr_q    <= cap_s && accept_s;
         if (cap_s) wdata_q <= i_rdata;
         if (cap_s && accept_s) waddr_q <= cnt_s;
      end
   end

   framebuf_addr_ctr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .FRAME_PIX  (FRAME_PIX)
   ) u_addr_ctr (
      .clk_i         (i_clk),
      .rstn_i        (i_rstn),
      .wr_i          (cap_s),
      .sof_i         (sof_act_s),
      .flush_i       (i_flush),
      .cnt_o         (cnt_s),
      .accept_o      (accept_s),
      .frame_done_o  (frame_done_s),
      .err_overrun_o (o_err_overrun),
      .err_short_o   (o_err_short)
   );

   assign o_rd         = rd_en_q;
   assign o_wr         = wr_q;
   assign o_waddr      = waddr_q;
   assign o_wdata      = wdata_q;
   assign o_frame_done = frame_done_s;

`ifdef FRAMEBUF_WRITER_STATS_EN
   logic [15:0]           frame_cnt_q;
   logic [ADDR_WIDTH-1:0] last_pix_q;

   // Completed-frame counter and pixel count seen at each frame restart.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         frame_cnt_q <= 16'd0;
         last_pix_q  <= {ADDR_WIDTH{1'b0}};
      end else if (i_flush) begin
         frame_cnt_q <= 16'd0;
         last_pix_q  <= {ADDR_WIDTH{1'b0}};
      end else begin
         if (frame_done_s) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (sof_act_s)    last_pix_q  <= cnt_s;
      end
   end

   assign o_frame_count    = frame_cnt_q;
   assign o_last_pix_count = last_pix_q;
`endif

endmodule
